// File: rtl/alu_mdu_pkg.sv
// Shared opcode, FSM-state and op-class definitions for the clocked ALU/MDU.
package alu_mdu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_MULTU = 3'b110;
  localparam logic [2:0] OP_DIVU  = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  function automatic logic is_multicycle(input logic [2:0] s);
    return s[2] & s[1];
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU: AND/OR/ADD/SUB/SLT/NOR, wrapping arithmetic.
module alu_comb
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// Clocked ALU with iterative unsigned multiply (shift-add) and restoring divide
// producing a HI/LO pair; busy stalls the EX stage while an op is in flight.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t state, state_n;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] wh, wl, b_r;
  logic [WIDTH-1:0] wh_n, wl_n;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH:0]   sum, sh;
  logic [WIDTH-1:0] dif;
  logic             last;

  alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
    .op (sel),
    .a  (data1),
    .b  (data2),
    .y  (alu_y)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign zero = (out == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = (state != IDLE);
    done    = (state == DONE);
    case (state)
      IDLE: begin
        if (start) begin
          if (!is_multicycle(sel))  state_n = DONE;
          else if (sel == OP_MULTU) state_n = MUL;
          else if (data2 == '0)     state_n = DONE;
          else                      state_n = DIV;
        end
      end
      MUL, DIV: if (last) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // wh:wl is the working pair: {partial product, multiplier} for MUL,
  // {partial remainder, dividend/quotient shift register} for DIV.
  always_comb begin
    wh_n = wh;
    wl_n = wl;
    sum  = {1'b0, wh} + (wl[0] ? {1'b0, b_r} : '0);
    sh   = {wh, wl[WIDTH-1]};
    dif  = sh[WIDTH-1:0] - b_r;
    if (state == MUL) begin
      wh_n = sum[WIDTH:1];
      wl_n = {sum[0], wl[WIDTH-1:1]};
    end else if (state == DIV) begin
      if (sh >= {1'b0, b_r}) begin
        wh_n = dif;
        wl_n = {wl[WIDTH-2:0], 1'b1};
      end else begin
        wh_n = sh[WIDTH-1:0];
        wl_n = {wl[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out         <= '0;
      hi          <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      wh          <= '0;
      wl          <= '0;
      b_r         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (!is_multicycle(sel)) begin
              out         <= alu_y;
              div_by_zero <= 1'b0;
            end else if (sel == OP_DIVU && data2 == '0) begin
              out         <= '1;
              hi          <= data1;
              div_by_zero <= 1'b1;
            end else begin
              wh  <= '0;
              wl  <= data1;
              b_r <= data2;
              cnt <= '0;
            end
          end
        end
        MUL, DIV: begin
          wh  <= wh_n;
          wl  <= wl_n;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            out         <= wl_n;
            hi          <= wh_n;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed scoreboard bench for alu_mdu at WIDTH=32.
module tb_alu_mdu;

  localparam int W = 32;

  logic         clk, rst, start;
  logic [2:0]   sel;
  logic [W-1:0] data1, data2;
  logic         busy, done, zero, div_by_zero;
  logic [W-1:0] out, hi;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] o;
    logic [W-1:0] h;
    logic         d;
    int           lat;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] mdl_hi;

  alu_mdu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sel         (sel),
    .data1       (data1),
    .data2       (data2),
    .busy        (busy),
    .done        (done),
    .out         (out),
    .hi          (hi),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input logic [2:0] s,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] cur_hi);
    exp_t e;
    logic [2*W-1:0] p;
    e.tag = tag; e.h = cur_hi; e.d = 1'b0; e.lat = 1; e.o = '0;
    case (s)
      3'b000: e.o = a & b;
      3'b001: e.o = a | b;
      3'b010: e.o = a + b;
      3'b011: e.o = a - b;
      3'b100: e.o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101: e.o = ~(a | b);
      3'b110: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.o = p[W-1:0]; e.h = p[2*W-1:W]; e.lat = W + 1;
      end
      default: begin
        if (b == 0) begin
          e.o = '1; e.h = a; e.d = 1'b1;
        end else begin
          e.o = a / b; e.h = a % b; e.lat = W + 1;
        end
      end
    endcase
    return e;
  endfunction

  // Push expectation, issue op, scramble inputs after acceptance, then pop and compare at done.
  task automatic run_op(input string tag, input logic [2:0] s,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   cyc;
    sb.push_back(model(tag, s, a, b, mdl_hi));
    @(negedge clk);
    start = 1'b1; sel = s; data1 = a; data2 = b;
    @(posedge clk); #1;
    start = 1'b0; sel = 3'($urandom); data1 = $urandom; data2 = $urandom;
    cyc = 1;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    mdl_hi = e.h;
    chk({e.tag, "_done"}, 64'(done), 64'd1);
    chk({e.tag, "_lat"}, 64'(cyc), 64'(e.lat));
    chk({e.tag, "_out"}, 64'(out), 64'(e.o));
    chk({e.tag, "_hi"}, 64'(hi), 64'(e.h));
    chk({e.tag, "_dbz"}, 64'(div_by_zero), 64'(e.d));
    chk({e.tag, "_zero"}, 64'(zero), 64'(e.o == '0));
    chk({e.tag, "_busy_in_done"}, 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk({e.tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({e.tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int ndone, dcyc;
    exp_t e;
    rst = 1'b1; start = 1'b0; sel = '0; data1 = '0; data2 = '0; mdl_hi = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op("add", 3'b010, 32'd7, 32'd9);
    run_op("sub", 3'b011, 32'd5, 32'd5);
    run_op("slt", 3'b100, 32'hFFFF_FFFF, 32'd1);
    run_op("nor", 3'b101, 32'd0, 32'd0);
    run_op("and", 3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF);
    run_op("or", 3'b001, 32'h8000_0001, 32'h0000_0010);
    run_op("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd2);
    run_op("multu", 3'b110, 32'hFFFF_FFFF, 32'd2);
    run_op("slt_hi_keep", 3'b100, 32'd3, 32'hFFFF_FFFE);
    run_op("multu_big", 3'b110, 32'hDEAD_BEEF, 32'h1234_5678);
    run_op("divu", 3'b111, 32'd100, 32'd7);
    run_op("divu_big", 3'b111, 32'hFFFF_FFFF, 32'h0001_0003);
    run_op("divu_zero", 3'b111, 32'd5, 32'd0);
    run_op("add_clr_dbz", 3'b010, 32'd1, 32'd0);
    run_op("divu_zero2", 3'b111, 32'd5, 32'd0);

    // MULTU 3x4 with ignored start pulses while busy
    sb.push_back(model("busy_ign", 3'b110, 32'd3, 32'd4, mdl_hi));
    @(negedge clk);
    start = 1'b1; sel = 3'b110; data1 = 32'd3; data2 = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; dcyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c >= 5 && c <= 10); sel = 3'b010; data1 = 32'd100; data2 = 32'd100;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (dcyc == 0) begin
          dcyc = c + 1;
          e = sb.pop_front();
          mdl_hi = e.h;
          chk("busy_ign_out", 64'(out), 64'(e.o));
          chk("busy_ign_hi", 64'(hi), 64'(e.h));
          chk("busy_ign_dbz", 64'(div_by_zero), 64'(e.d));
        end
      end
    end
    start = 1'b0;
    chk("busy_ign_ndone", 64'(ndone), 64'd1);
    chk("busy_ign_lat", 64'(dcyc), 64'(W + 1));
    chk("busy_ign_sb_empty", 64'(sb.size()), 64'd0);

    // Reset abort during DIVU
    @(negedge clk);
    start = 1'b1; sel = 3'b111; data1 = 32'd100; data2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_hi = '0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_out", 64'(out), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_zero", 64'(zero), 64'd1);
    chk("abort_dbz", 64'(div_by_zero), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", 64'(done), 64'd0);
    end
    run_op("post_abort_add", 3'b010, 32'd1, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
